fetch_debug_controller: RTL and testbench

FETCH_DEBUG_CONTROLLER -- requirements
Module: fetch_debug_controller

---
 rtl/fetch_debug_controller.sv | 187 ++++++++++++++++++
 tb/tb_fetch_debug_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_debug_controller.sv
// Fetch/debug controller: loads instruction memory from a byte stream and gates pipeline advance.
// Optional watchdog on free-run mode is enabled by defining FDC_WATCHDOG_EN.
module fetch_debug_controller #(
  parameter int NBITS       = 32,
  parameter int IMEM_DEPTH  = 64,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_halt,
  output logic             o_inst_mem_wr_en,
  output logic [NBITS-1:0] o_inst_mem_addr,
  output logic [NBITS-1:0] o_inst_mem_data,
  output logic             o_step,
  output logic [2:0]       o_state,
  output logic             o_load_err,
  output logic             o_wdog
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0]       CMD_L     = 8'h4C;
  localparam logic [7:0]       CMD_C     = 8'h43;
  localparam logic [7:0]       CMD_S     = 8'h53;
  localparam logic [31:0]      HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [NBITS-1:0] ADDR_END  = NBITS'(IMEM_DEPTH * 4);

  state_t           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      word_q, word_d;
  logic             wr_en_q, wr_en_d;
  logic [NBITS-1:0] mem_addr_q, mem_addr_d;
  logic [NBITS-1:0] mem_data_q, mem_data_d;
  logic             step_q, step_d;
  logic             load_err_q, load_err_d;
`ifdef FDC_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic             wdog_q, wdog_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    step_d     = 1'b0;
    load_err_d = load_err_q;
`ifdef FDC_WATCHDOG_EN
    wdog_cnt_d = wdog_cnt_q;
    wdog_d     = wdog_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_L) begin
            state_d    = LOAD;
            addr_d     = '0;
            idx_d      = '0;
            word_d     = '0;
            load_err_d = 1'b0;
`ifdef FDC_WATCHDOG_EN
            wdog_d     = 1'b0;
`endif
          end else if (state_q == IDLE && i_rx_data == CMD_C) begin
            state_d = RUN;
            step_d  = 1'b1;
`ifdef FDC_WATCHDOG_EN
            wdog_cnt_d = '0;
`endif
          end else if (state_q == IDLE && i_rx_data == CMD_S) begin
            state_d = STEP;
          end
        end
      end
      LOAD: begin
        if (i_rx_valid) begin
          idx_d = idx_q + 2'd1;
          word_d[{idx_q, 3'b000} +: 8] = i_rx_data;
          // A full word past the end of memory is dropped and flagged instead of written.
          if (idx_q == 2'd3) begin
            if (addr_q == ADDR_END) begin
              load_err_d = 1'b1;
              state_d    = IDLE;
            end else begin
              wr_en_d    = 1'b1;
              mem_addr_d = addr_q;
              mem_data_d = NBITS'(word_d);
              addr_d     = addr_q + NBITS'(4);
              if (word_d == HALT_WORD) state_d = IDLE;
            end
          end
        end
      end
      RUN: begin
        if (i_halt) begin
          state_d = DONE;
`ifdef FDC_WATCHDOG_EN
        end else if (wdog_cnt_q == WDW'(WDOG_CYCLES - 1)) begin
          state_d = DONE;
          wdog_d  = 1'b1;
        end else begin
          step_d     = 1'b1;
          wdog_cnt_d = wdog_cnt_q + WDW'(1);
`else
        end else begin
          step_d = 1'b1;
`endif
        end
      end
      STEP: begin
        // Halt takes priority over any byte arriving in the same cycle.
        if (i_halt) begin
          state_d = DONE;
        end else if (i_rx_valid) begin
          if (i_rx_data == CMD_S) begin
            step_d = 1'b1;
          end else if (i_rx_data == CMD_C) begin
            state_d = RUN;
            step_d  = 1'b1;
`ifdef FDC_WATCHDOG_EN
            wdog_cnt_d = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      step_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef FDC_WATCHDOG_EN
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      step_q     <= step_d;
      load_err_q <= load_err_d;
`ifdef FDC_WATCHDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign o_inst_mem_wr_en = wr_en_q;
  assign o_inst_mem_addr  = mem_addr_q;
  assign o_inst_mem_data  = mem_data_q;
  assign o_step           = step_q;
  assign o_state          = state_q;
  assign o_load_err       = load_err_q;
`ifdef FDC_WATCHDOG_EN
  assign o_wdog           = wdog_q;
`else
  assign o_wdog           = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_debug_controller.sv
// Directed-plus-random bench for fetch_debug_controller with a queue-based write model.
module tb_fetch_debug_controller;
  localparam int NB    = 32;
  localparam int DEPTH = 64;
  localparam int WD    = 16;
  localparam logic [7:0]  B_L   = 8'h4C;
  localparam logic [7:0]  B_C   = 8'h43;
  localparam logic [7:0]  B_S   = 8'h53;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [7:0]    rx_data  = '0;
  logic          rx_valid = 1'b0;
  logic          halt     = 1'b0;
  logic          wr_en;
  logic [NB-1:0] mem_addr;
  logic [NB-1:0] mem_data;
  logic          step;
  logic [2:0]    state;
  logic          load_err;
  logic          wdog;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_debug_controller #(
    .NBITS(NB), .IMEM_DEPTH(DEPTH), .WDOG_CYCLES(WD)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_halt(halt),
    .o_inst_mem_wr_en(wr_en), .o_inst_mem_addr(mem_addr), .o_inst_mem_data(mem_data),
    .o_step(step), .o_state(state), .o_load_err(load_err), .o_wdog(wdog)
  );

  // Passive monitor: records every write and counts step cycles and write/step overlaps.
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int step_total = 0;
  int overlap    = 0;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_data);
    end
    if (step === 1'b1) step_total++;
    if (wr_en === 1'b1 && step === 1'b1) overlap++;
  end

  logic [31:0] prog[$];
  int rd = 0;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic load_prog(input bit with_l);
    logic [31:0] w;
    if (with_l) send_byte(B_L);
    foreach (prog[i]) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, 2));
        send_byte(w[8*b +: 8]);
      end
    end
  endtask

  // Expected writes derived from the word list: sequential addresses from 0,
  // stop after a HALT word, drop the word that would land past the memory end.
  task automatic check_writes(input string tag);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] a;
    bit err;
    bit ended;
    int got;
    a = 0; err = 0; ended = 0;
    foreach (prog[i]) begin
      if (!ended) begin
        if (a == DEPTH * 4) begin
          err = 1; ended = 1;
        end else begin
          ea.push_back(a);
          ed.push_back(prog[i]);
          a += 4;
          if (prog[i] == HALTW) ended = 1;
        end
      end
    end
    idle(3);
    got = obs_addr.size() - rd;
    check({tag, " writes"}, got, ea.size());
    for (int k = 0; k < ea.size() && k < got; k++) begin
      check({tag, " addr"}, obs_addr[rd+k], ea[k]);
      check({tag, " data"}, obs_data[rd+k], ed[k]);
    end
    rd = obs_addr.size();
    check({tag, " load_err"}, load_err, err);
    check({tag, " state"}, state, ended ? 0 : 1);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    int base;

    #12;
    check("rst state", state, 0);
    check("rst wr_en", wr_en, 0);
    check("rst step", step, 0);
    check("rst load_err", load_err, 0);
    check("rst wdog", wdog, 0);
    check("rst addr", mem_addr, 0);
    check("rst data", mem_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("idle state", state, 0);

    prog = '{32'h2001_0013, HALTW};
    load_prog(1);
    check_writes("load_dir");

    prog.delete();
    n = $urandom_range(1, 6);
    repeat (n) begin
      w = $urandom;
      if (w == HALTW) w = 0;
      prog.push_back(w);
    end
    prog.push_back(HALTW);
    load_prog(1);
    check_writes("load_rand");

    prog.delete();
    repeat (DEPTH + 1) begin
      w = $urandom;
      if (w == HALTW) w = 32'h1;
      prog.push_back(w);
    end
    load_prog(1);
    check_writes("load_ovf");

    prog = '{32'h0000_1234, HALTW};
    load_prog(1);
    check_writes("load_clr");

    // Reset in the middle of a word.
    send_byte(B_L);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst_n = 1'b0;
    #1;
    check("arst state", state, 0);
    check("arst addr", mem_addr, 0);
    check("arst data", mem_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    idle(3);
    check("post_rst writes", obs_addr.size() - rd, 0);
    check("post_rst state", state, 0);
    rd = obs_addr.size();
    w = $urandom;
    if (w == HALTW) w = 0;
    prog = '{w, HALTW};
    load_prog(1);
    check_writes("load_after_rst");

    send_byte(B_S);
    check("step enter state", state, 3);
    check("step enter pulse", step, 0);
    base = step_total;
    n = 3 + $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      idle(9);
      send_byte(B_S);
      check("step pulse hi", step, 1);
      @(negedge clk);
      check("step pulse lo", step, 0);
    end
    send_byte(8'h5A);
    check("step junk", step, 0);
    send_byte(B_L);
    check("step ignores L", state, 3);
    idle(2);
    check("step count", step_total - base, n);

    base = step_total;
    @(negedge clk);
    rx_data = B_S; rx_valid = 1'b1; halt = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; halt = 1'b0;
    check("halt_wins state", state, 4);
    check("halt_wins pulse", step, 0);
    send_byte(B_C);
    send_byte(B_S);
    idle(2);
    check("done hold state", state, 4);
    check("halt_wins count", step_total - base, 0);

    prog = '{HALTW};
    load_prog(1);
    check_writes("load_from_done");

    base = step_total;
`ifdef FDC_WATCHDOG_EN
    n = $urandom_range(4, WD - 6);
`else
    n = $urandom_range(20, 40);
`endif
    send_byte(B_C);
    check("run state", state, 2);
    check("run step", step, 1);
    send_byte(B_L);
    check("run ignores rx", state, 2);
    idle(n - 3);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("run halt state", state, 4);
    check("run halt step", step, 0);
    check("run wdog", wdog, 0);
    idle(2);
    check("run step count", step_total - base, n);

`ifdef FDC_WATCHDOG_EN
    begin
      int cnt;
      prog = '{HALTW};
      load_prog(1);
      check_writes("load_wd");
      base = step_total;
      send_byte(B_C);
      cnt = 0;
      while (state !== 3'd4 && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      check("wd reached done", (cnt < 200), 1);
      idle(2);
      check("wd step count", step_total - base, WD);
      check("wd flag", wdog, 1);
      send_byte(B_L);
      check("wd clear", wdog, 0);
      prog = '{HALTW};
      load_prog(0);
      check_writes("load_wd_clr");
    end
`endif

    check("no wr/step overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
